// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write arbiter.
//   RF_AW / RF_DW   register address / data widths
//   SRC_ALU/SRC_MEM slot index of each writeback source
//   wr_req_t        one pending write request {addr, data}
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

  typedef struct packed {
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_wr_slot.sv
// rf_wr_slot: one-entry holding register for a pending RF write.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears vld only)
//   load            capture addr_in/data_in, slot becomes valid
//   drain           slot was granted this cycle; clears unless reloaded
//   addr_in/data_in incoming request
//   cmp1/cmp2       read addresses to compare against the held address
//   vld/addr/data   slot contents
//   hit1/hit2       slot valid and holds cmp1 / cmp2
module rf_wr_slot #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] data_in,
  input  logic [AW-1:0] cmp1,
  input  logic [AW-1:0] cmp2,
  output logic          vld,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          hit1,
  output logic          hit2
);

  // A reload in the drain cycle wins, so the slot stays valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

  // Payload is only meaningful while vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      addr <= addr_in;
      data <= data_in;
    end
  end

  assign hit1 = vld && (addr == cmp1);
  assign hit2 = vld && (addr == cmp2);

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the RF single write port between the ALU
// writeback (source 0) and the memory-load writeback (source 1).
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   SrcN_Valid/Addr/Data/Ready valid/ready write request per source
//   Awr, Din, WrEn             registered RF write port
//   Ard1, Ard2 -> Busy1, Busy2 pending-write hazard lookup
//   Conf_Cnt                   saturating count of cycles with both slots full
module rf_write_arbiter #(
  parameter int RF_AW = rf_pkg::RF_AW,
  parameter int RF_DW = rf_pkg::RF_DW,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Src0_Valid,
  input  logic [RF_AW-1:0] Src0_Addr,
  input  logic [RF_DW-1:0] Src0_Data,
  output logic             Src0_Ready,
  input  logic             Src1_Valid,
  input  logic [RF_AW-1:0] Src1_Addr,
  input  logic [RF_DW-1:0] Src1_Data,
  output logic             Src1_Ready,
  output logic [RF_AW-1:0] Awr,
  output logic [RF_DW-1:0] Din,
  output logic             WrEn,
  input  logic [RF_AW-1:0] Ard1,
  input  logic [RF_AW-1:0] Ard2,
  output logic             Busy1,
  output logic             Busy2,
  output logic [CNT_W-1:0] Conf_Cnt
);

  import rf_pkg::*;

  logic [1:0]       vld, gnt, load, hit1, hit2;
  logic [RF_AW-1:0] addr [2];
  logic [RF_DW-1:0] data [2];
  logic             old1;
  logic             any_gnt;
  logic [RF_AW-1:0] gnt_addr;
  logic [RF_DW-1:0] gnt_data;

  rf_wr_slot #(.AW(RF_AW), .DW(RF_DW)) u_slot_alu (
    .clk(Clk), .rst(Reset), .load(load[SRC_ALU]), .drain(gnt[SRC_ALU]),
    .addr_in(Src0_Addr), .data_in(Src0_Data), .cmp1(Ard1), .cmp2(Ard2),
    .vld(vld[SRC_ALU]), .addr(addr[SRC_ALU]), .data(data[SRC_ALU]),
    .hit1(hit1[SRC_ALU]), .hit2(hit2[SRC_ALU])
  );

  rf_wr_slot #(.AW(RF_AW), .DW(RF_DW)) u_slot_mem (
    .clk(Clk), .rst(Reset), .load(load[SRC_MEM]), .drain(gnt[SRC_MEM]),
    .addr_in(Src1_Addr), .data_in(Src1_Data), .cmp1(Ard1), .cmp2(Ard2),
    .vld(vld[SRC_MEM]), .addr(addr[SRC_MEM]), .data(data[SRC_MEM]),
    .hit1(hit1[SRC_MEM]), .hit2(hit2[SRC_MEM])
  );

  // Oldest-first grant; with a single valid slot the age flag is ignored.
  always_comb begin
    gnt = vld;
    if (vld[SRC_ALU] && vld[SRC_MEM]) begin
      gnt          = '0;
      gnt[SRC_MEM] = old1;
      gnt[SRC_ALU] = !old1;
    end
  end

  // A slot refills in the same cycle it drains, giving 1 request/cycle.
  assign Src0_Ready    = !Reset && (!vld[SRC_ALU] || gnt[SRC_ALU]);
  assign Src1_Ready    = !Reset && (!vld[SRC_MEM] || gnt[SRC_MEM]);
  assign load[SRC_ALU] = Src0_Valid && Src0_Ready;
  assign load[SRC_MEM] = Src1_Valid && Src1_Ready;

  assign any_gnt  = |gnt;
  assign gnt_addr = gnt[SRC_MEM] ? addr[SRC_MEM] : addr[SRC_ALU];
  assign gnt_data = gnt[SRC_MEM] ? data[SRC_MEM] : data[SRC_ALU];

  // Age flag: a slot left waiting is older than whatever the other slot
  // loads now. Simultaneous fresh loads make slot 0 the older one; the
  // explicit clear matters when a stale old1 survived a single-slot period.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      old1 <= 1'b0;
    end else if (vld[SRC_MEM] && !gnt[SRC_MEM] && load[SRC_ALU]) begin
      old1 <= 1'b1;
    end else if (vld[SRC_ALU] && !gnt[SRC_ALU] && load[SRC_MEM]) begin
      old1 <= 1'b0;
    end else if (load[SRC_ALU] && load[SRC_MEM]) begin
      old1 <= 1'b0;
    end
  end

  // Write-port register. Register 0 writes are consumed but never issued;
  // address/data are zeroed so the port shows no stale target.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      WrEn <= 1'b0;
      Awr  <= '0;
      Din  <= '0;
    end else if (any_gnt && (gnt_addr != '0)) begin
      WrEn <= 1'b1;
      Awr  <= gnt_addr;
      Din  <= gnt_data;
    end else if (any_gnt) begin
      WrEn <= 1'b0;
      Awr  <= '0;
      Din  <= '0;
    end else begin
      WrEn <= 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Conf_Cnt <= '0;
    end else if (vld[SRC_ALU] && vld[SRC_MEM] && !(&Conf_Cnt)) begin
      Conf_Cnt <= Conf_Cnt + 1'b1;
    end
  end

  // Hazard lookup covers both slots and the write already on the port.
  assign Busy1 = (Ard1 != '0) && ((|hit1) || (WrEn && (Awr == Ard1)));
  assign Busy2 = (Ard2 != '0) && ((|hit2) || (WrEn && (Awr == Ard2)));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed-vector bench for rf_write_arbiter.
module tb_rf_write_arbiter;

  logic        Clk;
  logic        Reset;
  logic        Src0_Valid, Src1_Valid;
  logic [4:0]  Src0_Addr, Src1_Addr;
  logic [31:0] Src0_Data, Src1_Data;
  logic        Src0_Ready, Src1_Ready;
  logic [4:0]  Awr;
  logic [31:0] Din;
  logic        WrEn;
  logic [4:0]  Ard1, Ard2;
  logic        Busy1, Busy2;
  logic [15:0] Conf_Cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf_model [32];

  rf_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Src0_Valid(Src0_Valid), .Src0_Addr(Src0_Addr), .Src0_Data(Src0_Data), .Src0_Ready(Src0_Ready),
    .Src1_Valid(Src1_Valid), .Src1_Addr(Src1_Addr), .Src1_Data(Src1_Data), .Src1_Ready(Src1_Ready),
    .Awr(Awr), .Din(Din), .WrEn(WrEn),
    .Ard1(Ard1), .Ard2(Ard2), .Busy1(Busy1), .Busy2(Busy2),
    .Conf_Cnt(Conf_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register file as seen through the write port.
  always @(posedge Clk) begin
    if (WrEn) rf_model[Awr] <= Din;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    Reset = 1'b1;
    Src0_Valid = 0; Src0_Addr = 0; Src0_Data = 0;
    Src1_Valid = 0; Src1_Addr = 0; Src1_Data = 0;
    Ard1 = 0; Ard2 = 0;

    // Reset state
    tick(); tick();
    chk("rst_ready0", Src0_Ready, 0);
    chk("rst_ready1", Src1_Ready, 0);
    chk("rst_wren", WrEn, 0);
    chk("rst_awr", Awr, 0);
    chk("rst_din", Din, 0);
    chk("rst_cnt", Conf_Cnt, 0);
    Reset = 1'b0;
    #1;
    chk("rel_ready0", Src0_Ready, 1);

    // Single uncontended write
    Src0_Valid = 1; Src0_Addr = 5; Src0_Data = 32'hDEADBEEF;
    #1 chk("t1_ready_pre", Src0_Ready, 1);
    tick();
    Src0_Valid = 0;
    #1;
    chk("t1_ready_held", Src0_Ready, 1);
    chk("t1_wren_early", WrEn, 0);
    tick();
    chk("t1_wren", WrEn, 1);
    chk("t1_awr", Awr, 5);
    chk("t1_din", Din, 32'hDEADBEEF);
    tick();
    chk("t1_wren_off", WrEn, 0);
    chk("t1_awr_hold", Awr, 5);

    // Same-cycle accept, same address
    Src0_Valid = 1; Src0_Addr = 3; Src0_Data = 32'h11;
    Src1_Valid = 1; Src1_Addr = 3; Src1_Data = 32'h22;
    tick();
    Src0_Valid = 0; Src1_Valid = 0;
    chk("t2_cnt0", Conf_Cnt, 0);
    tick();
    chk("t2_first_awr", Awr, 3);
    chk("t2_first_din", Din, 32'h11);
    chk("t2_cnt1", Conf_Cnt, 1);
    tick();
    chk("t2_second_wren", WrEn, 1);
    chk("t2_second_din", Din, 32'h22);
    chk("t2_cnt_hold", Conf_Cnt, 1);
    tick(); tick();
    chk("t2_r3", rf_model[3], 32'h22);
    chk("t2_r5", rf_model[5], 32'hDEADBEEF);

    // Src1 waits while Src0 streams
    Src0_Valid = 1; Src0_Addr = 10; Src0_Data = 32'h1010;
    tick();
    Src0_Addr = 11; Src0_Data = 32'h1111;
    Src1_Valid = 1; Src1_Addr = 7; Src1_Data = 32'h77;
    tick();
    chk("t3_awr10", Awr, 10);
    Src1_Valid = 0;
    Src0_Addr = 12; Src0_Data = 32'h1212;
    #1;
    chk("t3_ready0_a", Src0_Ready, 1);
    chk("t3_ready1_a", Src1_Ready, 0);
    tick();
    chk("t3_awr11", Awr, 11);
    chk("t3_cnt2", Conf_Cnt, 2);
    Src0_Addr = 13; Src0_Data = 32'h1313;
    #1 chk("t3_ready0_blocked", Src0_Ready, 0);
    tick();
    chk("t3_awr7", Awr, 7);
    chk("t3_din77", Din, 32'h77);
    chk("t3_cnt3", Conf_Cnt, 3);
    tick();
    chk("t3_awr12", Awr, 12);
    Src0_Valid = 0;
    tick();
    chk("t3_awr13", Awr, 13);
    chk("t3_din13", Din, 32'h1313);
    chk("t3_cnt_hold", Conf_Cnt, 3);
    tick();

    // Continuous contention: alternation and counter saturation
    Src0_Valid = 1; Src0_Addr = 20; Src0_Data = 32'hA0000000;
    Src1_Valid = 1; Src1_Addr = 21; Src1_Data = 32'hB0000000;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_wren", WrEn, 1);
      chk("alt_awr", Awr, (i % 2 == 0) ? 20 : 21);
      chk("alt_ready0", Src0_Ready, (i % 2 == 0) ? 0 : 1);
      chk("alt_ready1", Src1_Ready, (i % 2 == 0) ? 1 : 0);
    end
    chk("alt_cnt7", Conf_Cnt, 7);
    repeat (65540) tick();
    chk("sat_cnt", Conf_Cnt, 16'hFFFF);
    tick();
    chk("sat_cnt_hold", Conf_Cnt, 16'hFFFF);
    Src0_Valid = 0; Src1_Valid = 0;
    tick(); tick(); tick();
    chk("drain_wren", WrEn, 0);

    // Register 0 write is dropped
    Ard1 = 0; Ard2 = 0;
    Src0_Valid = 1; Src0_Addr = 0; Src0_Data = 32'hFFFFFFFF;
    tick();
    Src0_Valid = 0;
    #1;
    chk("z_busy1", Busy1, 0);
    chk("z_busy2", Busy2, 0);
    chk("z_ready0", Src0_Ready, 1);
    tick();
    chk("z_wren", WrEn, 0);
    chk("z_awr", Awr, 0);
    chk("z_din", Din, 0);
    chk("z_busy1_out", Busy1, 0);
    tick();
    chk("z_ready0_after", Src0_Ready, 1);

    // Hazard lookup through slot and output stage
    Ard1 = 9; Ard2 = 8;
    Src0_Valid = 1; Src0_Addr = 9; Src0_Data = 32'h99;
    #1 chk("h_busy1_pre", Busy1, 0);
    tick();
    Src0_Valid = 0;
    #1;
    chk("h_busy1_slot", Busy1, 1);
    chk("h_busy2_slot", Busy2, 0);
    tick();
    chk("h_wren9", WrEn, 1);
    chk("h_busy1_out", Busy1, 1);
    tick();
    chk("h_busy1_clr", Busy1, 0);
    Src1_Valid = 1; Src1_Addr = 8; Src1_Data = 32'h88;
    tick();
    Src1_Valid = 0;
    #1;
    chk("h_busy2_slot1", Busy2, 1);
    chk("h_busy1_other", Busy1, 0);
    tick();
    chk("h_busy2_out", Busy2, 1);
    tick();
    chk("h_busy2_clr", Busy2, 0);

    // Asynchronous reset with both slots full and a write on the port
    Ard1 = 6; Ard2 = 0;
    Src0_Valid = 1; Src0_Addr = 4; Src0_Data = 32'h44;
    Src1_Valid = 1; Src1_Addr = 6; Src1_Data = 32'h66;
    tick();
    Src1_Valid = 0;
    tick();
    chk("r_wren_pre", WrEn, 1);
    chk("r_awr_pre", Awr, 4);
    chk("r_busy1_pre", Busy1, 1);
    #2 Reset = 1'b1;
    #1;
    chk("r_wren", WrEn, 0);
    chk("r_awr", Awr, 0);
    chk("r_din", Din, 0);
    chk("r_cnt", Conf_Cnt, 0);
    chk("r_ready0", Src0_Ready, 0);
    chk("r_ready1", Src1_Ready, 0);
    chk("r_busy1", Busy1, 0);
    Src0_Valid = 0;
    tick();
    Reset = 1'b0;
    #1;
    chk("r_ready0_rel", Src0_Ready, 1);
    chk("r_ready1_rel", Src1_Ready, 1);
    tick();
    chk("r_no_write_a", WrEn, 0);
    tick();
    chk("r_no_write_b", WrEn, 0);
    chk("r_cnt_rel", Conf_Cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
